// File: rtl/dt_pkg.sv
// Shared types and sizes for the distance-transform result-memory path.
package dt_pkg;

   localparam int unsigned DT_IMG_W  = 128;
   localparam int unsigned DT_ADDR_W = $clog2(DT_IMG_W * DT_IMG_W);
   localparam int unsigned DT_DATA_W = 8;

   typedef logic req_id_t;

   function automatic logic [1:0] id2oh(input req_id_t id);
      return id ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/dt_rr_pick2.sv
// Combinational two-way round-robin picker with lock-owner override.
module dt_rr_pick2
   import dt_pkg::*;
(
   input  logic [1:0] i_req,
   input  req_id_t    i_last,
   input  logic       i_own_vld,
   input  req_id_t    i_own_id,
   input  logic       i_lock_ok,
   output logic [1:0] o_gnt
);

   always_comb begin
      o_gnt = 2'b00;
      if (i_own_vld && i_lock_ok && i_req[i_own_id]) begin
         o_gnt = id2oh(i_own_id);
      end else begin
         case (i_req)
            2'b01:   o_gnt = 2'b01;
            2'b10:   o_gnt = 2'b10;
            // On a tie the requester not served last wins; after lock expiry this is the other one.
            2'b11:   o_gnt = id2oh(~i_last);
            default: o_gnt = 2'b00;
         endcase
      end
   end

endmodule

// File: rtl/dt_res_arbiter.sv
// Two-requester arbiter for the single-port DT result memory with burst lock,
// registered memory-side strobes and requester-tagged read return.
module dt_res_arbiter
   import dt_pkg::*;
#(
   parameter int unsigned ADDR_W   = DT_ADDR_W,
   parameter int unsigned DATA_W   = DT_DATA_W,
   parameter int unsigned MAX_LOCK = 8
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic [1:0]        i_req,
   input  logic [1:0]        i_lock,
   input  logic [1:0]        i_we,
   input  logic [ADDR_W-1:0] i_addr0,
   input  logic [ADDR_W-1:0] i_addr1,
   input  logic [DATA_W-1:0] i_wdata0,
   input  logic [DATA_W-1:0] i_wdata1,
   output logic [1:0]        o_gnt,
   output logic [1:0]        o_rvalid,
   output logic [DATA_W-1:0] o_rdata,
   output logic              o_res_rd,
   output logic              o_res_wr,
   output logic [ADDR_W-1:0] o_res_addr,
   output logic [DATA_W-1:0] o_res_do,
   input  logic [DATA_W-1:0] i_res_di
);

   localparam int unsigned CNT_W = $clog2(MAX_LOCK + 1);

   req_id_t             r_last;
   logic                r_own_vld;
   req_id_t             r_own_id;
   logic [CNT_W-1:0]    r_lock_cnt;
   logic                r_res_rd;
   logic                r_res_wr;
   logic [ADDR_W-1:0]   r_res_addr;
   logic [DATA_W-1:0]   r_res_do;
   req_id_t             r_rd_id;
   logic [1:0]          r_rvalid;
   logic [DATA_W-1:0]   r_rdata;

   req_id_t             w_last_nxt;
   logic                w_own_vld_nxt;
   req_id_t             w_own_id_nxt;
   logic [CNT_W-1:0]    w_lock_cnt_nxt;
   logic                w_res_rd_nxt;
   logic                w_res_wr_nxt;
   logic [ADDR_W-1:0]   w_res_addr_nxt;
   logic [DATA_W-1:0]   w_res_do_nxt;
   req_id_t             w_rd_id_nxt;
   logic [1:0]          w_rvalid_nxt;
   logic [DATA_W-1:0]   w_rdata_nxt;

   logic [1:0]          w_pick;
   logic [1:0]          w_gnt;
   logic                w_gnt_vld;
   req_id_t             w_gnt_id;
   logic                w_lock_ok;

   assign w_lock_ok = (r_lock_cnt < CNT_W'(MAX_LOCK));

   dt_rr_pick2 u_pick (
      .i_req     (i_req),
      .i_last    (r_last),
      .i_own_vld (r_own_vld),
      .i_own_id  (r_own_id),
      .i_lock_ok (w_lock_ok),
      .o_gnt     (w_pick)
   );

   // No grant is offered while reset is held.
   assign w_gnt     = i_reset ? 2'b00 : w_pick;
   assign w_gnt_vld = |w_gnt;
   assign w_gnt_id  = w_gnt[1];

   always_comb begin
      w_last_nxt     = r_last;
      // Without a grant the owner is not requesting, so ownership lapses.
      w_own_vld_nxt  = 1'b0;
      w_own_id_nxt   = r_own_id;
      w_lock_cnt_nxt = '0;
      w_res_rd_nxt   = 1'b0;
      w_res_wr_nxt   = 1'b0;
      w_res_addr_nxt = r_res_addr;
      w_res_do_nxt   = r_res_do;
      w_rd_id_nxt    = r_rd_id;

      if (w_gnt_vld) begin
         w_last_nxt     = w_gnt_id;
         w_res_rd_nxt   = ~i_we[w_gnt_id];
         w_res_wr_nxt   = i_we[w_gnt_id];
         w_res_addr_nxt = w_gnt_id ? i_addr1 : i_addr0;
         w_res_do_nxt   = w_gnt_id ? i_wdata1 : i_wdata0;
         w_rd_id_nxt    = w_gnt_id;
         if (i_lock[w_gnt_id]) begin
            w_own_vld_nxt = 1'b1;
            w_own_id_nxt  = w_gnt_id;
            // An expired owner re-granted alone starts a fresh burst.
            if (r_own_vld && (r_own_id == w_gnt_id) && w_lock_ok) begin
               w_lock_cnt_nxt = r_lock_cnt + CNT_W'(1);
            end else begin
               w_lock_cnt_nxt = CNT_W'(1);
            end
         end
      end

      w_rvalid_nxt = r_res_rd ? id2oh(r_rd_id) : 2'b00;
      w_rdata_nxt  = r_res_rd ? i_res_di : r_rdata;
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_last     <= 1'b1;
         r_own_vld  <= 1'b0;
         r_own_id   <= 1'b0;
         r_lock_cnt <= '0;
         r_res_rd   <= 1'b0;
         r_res_wr   <= 1'b0;
         r_res_addr <= '0;
         r_res_do   <= '0;
         r_rd_id    <= 1'b0;
         r_rvalid   <= 2'b00;
         r_rdata    <= '0;
      end else begin
         r_last     <= w_last_nxt;
         r_own_vld  <= w_own_vld_nxt;
         r_own_id   <= w_own_id_nxt;
         r_lock_cnt <= w_lock_cnt_nxt;
         r_res_rd   <= w_res_rd_nxt;
         r_res_wr   <= w_res_wr_nxt;
         r_res_addr <= w_res_addr_nxt;
         r_res_do   <= w_res_do_nxt;
         r_rd_id    <= w_rd_id_nxt;
         r_rvalid   <= w_rvalid_nxt;
         r_rdata    <= w_rdata_nxt;
      end
   end

   always_comb begin
      o_gnt      = w_gnt;
      o_rvalid   = r_rvalid;
      o_rdata    = r_rdata;
      o_res_rd   = r_res_rd;
      o_res_wr   = r_res_wr;
      o_res_addr = r_res_addr;
      o_res_do   = r_res_do;
   end

endmodule

// File: tb/tb_dt_res_arbiter.sv
// Directed bench for dt_res_arbiter with a small behavioural result memory.
module tb_dt_res_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  req, lock, we;
   logic [13:0] addr0, addr1;
   logic [7:0]  wdata0, wdata1;
   logic [1:0]  gnt, rvalid;
   logic [7:0]  rdata, res_do, res_di;
   logic        res_rd, res_wr;
   logic [13:0] res_addr;

   logic [7:0]  mem [0:16383];
   logic        preset;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   dt_res_arbiter #(.ADDR_W(14), .DATA_W(8), .MAX_LOCK(8)) dut (
      .i_clk      (clk),
      .i_reset    (rst),
      .i_req      (req),
      .i_lock     (lock),
      .i_we       (we),
      .i_addr0    (addr0),
      .i_addr1    (addr1),
      .i_wdata0   (wdata0),
      .i_wdata1   (wdata1),
      .o_gnt      (gnt),
      .o_rvalid   (rvalid),
      .o_rdata    (rdata),
      .o_res_rd   (res_rd),
      .o_res_wr   (res_wr),
      .o_res_addr (res_addr),
      .o_res_do   (res_do),
      .i_res_di   (res_di)
   );

   always @(posedge clk) begin
      if (preset) begin
         mem[129] <= 8'h05;
         mem[0]   <= 8'h11;
         mem[1]   <= 8'h22;
         mem[2]   <= 8'h33;
         mem[128] <= 8'h44;
         mem[300] <= 8'h66;
      end else if (res_wr) begin
         mem[res_addr] <= res_do;
      end
   end

   assign res_di = mem[res_addr];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Leaves the caller on a falling edge with reset just released.
   task automatic do_reset();
      @(negedge clk);
      rst  = 1'b1;
      req  = 2'b00;
      lock = 2'b00;
      we   = 2'b00;
      @(negedge clk);
      @(negedge clk);
      rst  = 1'b0;
   endtask

   logic [13:0] s3_addr [4];
   logic [7:0]  s3_data [4];
   logic [1:0]  exp_gnt;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      s3_addr = '{14'd0, 14'd1, 14'd2, 14'd128};
      s3_data = '{8'h11, 8'h22, 8'h33, 8'h44};
      rst = 1'b1; req = 2'b00; lock = 2'b00; we = 2'b00;
      addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
      preset = 1'b1;
      repeat (3) @(negedge clk);
      preset = 1'b0;
      #1;
      chk("rst_gnt", gnt, 0);
      chk("rst_rvalid", rvalid, 0);
      chk("rst_res_rd", res_rd, 0);
      chk("rst_res_wr", res_wr, 0);
      chk("rst_res_addr", res_addr, 0);
      chk("rst_res_do", res_do, 0);
      chk("rst_rdata", rdata, 0);

      // Single read of addr 129 from requester 0
      @(negedge clk);
      rst = 1'b0; req = 2'b01; we = 2'b00; addr0 = 14'd129;
      #1 chk("s1_gnt", gnt, 2'b01);
      @(negedge clk);
      req = 2'b00;
      #1;
      chk("s1_gnt_idle", gnt, 0);
      chk("s1_res_rd", res_rd, 1);
      chk("s1_res_wr", res_wr, 0);
      chk("s1_res_addr", res_addr, 129);
      chk("s1_rvalid_early", rvalid, 0);
      @(negedge clk);
      #1;
      chk("s1_rvalid", rvalid, 2'b01);
      chk("s1_rdata", rdata, 5);
      chk("s1_res_rd_drop", res_rd, 0);
      chk("s1_addr_hold", res_addr, 129);
      @(negedge clk);
      #1;
      chk("s1_rvalid_pulse", rvalid, 0);
      chk("s1_rdata_hold", rdata, 5);

      // Both requesting without lock: strict alternation
      do_reset();
      req = 2'b11; addr0 = 14'd10; addr1 = 14'd20;
      for (int k = 0; k < 5; k++) begin
         if (k != 0) @(negedge clk);
         if (k == 4) req = 2'b00;
         #1;
         exp_gnt = (k == 4) ? 2'b00 : ((k % 2 == 1) ? 2'b10 : 2'b01);
         chk("s2_gnt", gnt, exp_gnt);
         if (k >= 1) chk("s2_res_addr", res_addr, ((k - 1) % 2 == 1) ? 20 : 10);
         if (k >= 2) chk("s2_rvalid", rvalid, ((k - 2) % 2 == 1) ? 2'b10 : 2'b01);
      end

      // Locked 4-read burst by requester 0 while requester 1 waits
      do_reset();
      addr1 = 14'd300;
      for (int k = 0; k < 7; k++) begin
         if (k != 0) @(negedge clk);
         req  = (k < 4) ? 2'b11 : ((k == 4) ? 2'b10 : 2'b00);
         lock = (k < 4) ? 2'b01 : 2'b00;
         if (k < 4) addr0 = s3_addr[k];
         #1;
         exp_gnt = (k < 4) ? 2'b01 : ((k == 4) ? 2'b10 : 2'b00);
         chk("s3_gnt", gnt, exp_gnt);
         if (k >= 1 && k <= 4) chk("s3_res_addr", res_addr, s3_addr[k-1]);
         if (k == 5) chk("s3_res_addr_r1", res_addr, 300);
         if (k >= 2 && k <= 5) begin
            chk("s3_rvalid", rvalid, 2'b01);
            chk("s3_rdata", rdata, s3_data[k-2]);
         end
         if (k == 6) begin
            chk("s3_rvalid_r1", rvalid, 2'b10);
            chk("s3_rdata_r1", rdata, 8'h66);
         end
      end

      // Lock expiry after 8 consecutive grants
      do_reset();
      req = 2'b11; lock = 2'b01; addr1 = 14'd500;
      for (int k = 0; k < 11; k++) begin
         if (k != 0) @(negedge clk);
         addr0 = 14'(k);
         #1;
         chk("s4_gnt", gnt, (k == 8) ? 2'b10 : 2'b01);
      end
      @(negedge clk);
      req = 2'b00; lock = 2'b00;

      // Write by requester 1 then read-back by requester 0
      do_reset();
      req = 2'b10; we = 2'b10; addr1 = 14'd200; wdata1 = 8'd7;
      #1 chk("s5_gnt_wr", gnt, 2'b10);
      @(negedge clk);
      req = 2'b01; we = 2'b00; addr0 = 14'd200;
      #1;
      chk("s5_gnt_rd", gnt, 2'b01);
      chk("s5_res_wr", res_wr, 1);
      chk("s5_res_rd0", res_rd, 0);
      chk("s5_res_addr_wr", res_addr, 200);
      chk("s5_res_do", res_do, 7);
      @(negedge clk);
      req = 2'b00;
      #1;
      chk("s5_res_rd", res_rd, 1);
      chk("s5_res_wr_drop", res_wr, 0);
      chk("s5_rvalid_early", rvalid, 0);
      @(negedge clk);
      #1;
      chk("s5_rvalid", rvalid, 2'b01);
      chk("s5_rdata", rdata, 7);

      // Reset the cycle after a read grant
      do_reset();
      req = 2'b01; we = 2'b00; addr0 = 14'd129;
      #1 chk("s6_gnt", gnt, 2'b01);
      @(negedge clk);
      req = 2'b00; rst = 1'b1;
      #1;
      chk("s6_gnt_in_rst", gnt, 0);
      chk("s6_res_rd_pre", res_rd, 1);
      @(negedge clk);
      rst = 1'b0; req = 2'b11; addr0 = 14'd1; addr1 = 14'd2;
      #1;
      chk("s6_res_rd", res_rd, 0);
      chk("s6_res_wr", res_wr, 0);
      chk("s6_rvalid", rvalid, 0);
      chk("s6_tie_gnt", gnt, 2'b01);
      @(negedge clk);
      req = 2'b00;
      #1;
      chk("s6_rvalid_late", rvalid, 0);
      chk("s6_res_addr", res_addr, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/dt_res_arbiter.md
# dt_res_arbiter

Two-requester arbiter sharing the single-port 16384×8 distance-transform result memory (`res_*` port) between the forward/backward-pass engine and a second client (host readout or debug scrubber). It grants one access per cycle using round-robin priority, lets a requester lock the port for a multi-access burst such as a neighbour-window read, and returns read data tagged to the requester that issued the read. All memory-side outputs are registered.

## Interface
- `ADDR_W`, 14: result memory address width (128×128 image).
- `DATA_W`, 8: result pixel width.
- `MAX_LOCK`, 8: maximum consecutive locked grants before a forced re-arbitration.
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req[1:0]`  in  2  per-requester access request, held until granted.
- `lock[1:0]`  in  2  requester i asks to keep ownership after the current grant.
- `we[1:0]`  in  2  1 = write, 0 = read, per requester.
- `addr0`, `addr1`  in  ADDR_W each  per-requester address.
- `wdata0`, `wdata1`  in  DATA_W each  per-requester write data.
- `gnt[1:0]`  out  2  one-hot or zero; request accepted this cycle (combinational).
- `rvalid[1:0]`  out  2  one-cycle read-data strobe to requester i.
- `rdata`  out  DATA_W  read data, valid when any `rvalid` bit is high.
- `res_rd`  out  1  memory read strobe.
- `res_wr`  out  1  memory write strobe.
- `res_addr`  out  ADDR_W  memory address.
- `res_do`  out  DATA_W  memory write data.
- `res_di`  in  DATA_W  memory read data, valid in the same cycle as `res_rd`.

## Operation
- State: `last` (1 bit, last granted requester), `owner` (valid bit + id) for lock, `lock_cnt` (⌈log2(MAX_LOCK+1)⌉ bits), `rd_pend` (valid + id).
- Grant rule, evaluated each cycle:
  - Owner valid, `req[owner]` high, `lock_cnt < MAX_LOCK`: grant owner.
  - Otherwise, one request: grant it. Two requests: grant `!last`.
- Owner valid but `req[owner]` low: ownership released immediately; arbitrate normally in that cycle.
- On grant to i:
  - `last <= i`.
  - If `lock[i]`: `owner <= i`; `lock_cnt` increments when i was already owner, else set to 1.
  - If `!lock[i]`: owner cleared, `lock_cnt <= 0`.
- Lock expiry: when `lock_cnt == MAX_LOCK` with both requesting, the other requester is granted and ownership is cleared. With only the owner requesting, the owner is granted and `lock_cnt` restarts at 1.
- Issue: the registered `res_rd = gnt_i & !we_i` and `res_wr = gnt_i & we_i`; `res_addr`/`res_do` are taken from the granted requester. With no grant, both strobes are 0 and `res_addr`/`res_do` hold.
- Return: a cycle with `res_rd` high captures `res_di` into `rdata` and pulses `rvalid[id]` the following cycle. `rdata` holds between reads.

## Timing
- Reset values: `gnt`, `rvalid`, `res_rd`, `res_wr` = 0; `res_addr`, `res_do`, `rdata` = 0; `last` = 1, so requester 0 wins the first tie; owner invalid; `lock_cnt` = 0; `rd_pend` invalid.
- Latency: grant in cycle t → strobe in t+1 → `rvalid` in t+2.
- Throughput: one access per cycle, back-to-back, with no bubble on requester switch.
- Write followed by a read of the same address on the next grant returns the new data; no internal forwarding is needed.
- Reset asserted mid-burst: strobes drop at the next edge. An in-flight read's `rvalid` is suppressed and lock ownership is lost.
- `lock` without `req` is ignored.
- `we` and `addr` are only sampled in a granted cycle.

## Structure
- The shared `dt_pkg` holds:
  - `DT_ADDR_W` = 14 and `DT_DATA_W` = 8.
  - `DT_IMG_W` = 128.
  - typedef `req_id_t` (1 bit).
- Sub-module `dt_rr_pick2`: a pure combinational two-way round-robin picker (inputs `req`, `last`, owner/lock qualifiers; output one-hot `gnt`). The top module holds all registers.

## Test plan
- Reset release, then `req`=01, `we0`=0, `addr0`=129, mem[129]=5 → `gnt`=01 at t; `res_rd`=1, `res_addr`=129 at t+1; `rvalid`=01, `rdata`=5 at t+2.
- Both requesting continuously without lock → `gnt` alternates 01,10,01,…, starting 01; `res_addr` alternates accordingly each cycle.
- Requester 0 requests with lock for 4 reads (addr 0,1,2,128) while requester 1 requests → four consecutive `gnt`=01, then `gnt`=10 once lock drops.
- `MAX_LOCK`=8, requester 0 requests with lock continuously and requester 1 requests → after 8 grants to 0, one grant to 1, then requester 0 is re-granted.
- Requester 1 writes 7 to addr 200 at t, requester 0 reads addr 200 at t+1 → `res_wr`=1 at t+1, then `rdata`=7 with `rvalid`=01 at t+3.
- `reset` asserted the cycle after a read grant → `rvalid` stays 0, all strobes are 0, and the next tie grants requester 0.
